alu_issue_arbiter: RTL and testbench

Shares the single combinational 64-bit uPower ALU between two requesters: requester 0 is the instruction execute pipe, requester 1 is the load/store address-generation unit. Each request is accepted with a valid/ready handshake. The block latches the operands into an issue register, drives the ALU for a programmable number of settle cycles, captures the result and branch flag, and returns them with the requester id over a valid/ready response channel. It sits between decode/AGU and writeback, directly in front of the ALU.

---
 rtl/alu_issue_arbiter.sv | 175 +++++++++++++++++
 tb/tb_alu_issue_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter: shares one combinational 64-bit ALU between the execute
// pipe (requester 0) and the load/store AGU (requester 1). One request is in
// flight at a time: IDLE -> EXEC (settle cycles) -> RESP (response handshake).
// Optional statistics counters are built when ALU_ARB_STATS_EN is defined.
module alu_issue_arbiter #(
    parameter int unsigned EXEC_CYCLES = 1,
    parameter int unsigned CNT_W       = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [55:0] req0_ctl,
    input  logic [63:0] req0_ra,
    input  logic [63:0] req0_rb,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [55:0] req1_ctl,
    input  logic [63:0] req1_ra,
    input  logic [63:0] req1_rb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [63:0] rsp_result,
    output logic        rsp_branch,
    output logic [55:0] alu_ctl,
    output logic [63:0] alu_ra,
    output logic [63:0] alu_rb,
    input  logic [63:0] alu_result,
    input  logic        alu_branch
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_grant0,
    output logic [CNT_W-1:0] stat_grant1,
    output logic [CNT_W-1:0] stat_stall
`endif
);

    // A zero setting still needs one settle cycle.
    localparam int unsigned EXEC_N = (EXEC_CYCLES == 0) ? 1 : EXEC_CYCLES;
    localparam int unsigned CW     = $clog2(EXEC_N + 1);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic            id_q, id_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [55:0]     ctl_q, ctl_d;
    logic [63:0]     ra_q, ra_d;
    logic [63:0]     rb_q, rb_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_id_q, rsp_id_d;
    logic [63:0]     rsp_result_q, rsp_result_d;
    logic            rsp_branch_q, rsp_branch_d;

    logic            grant;
    logic            hs;

    // Round-robin pick: a tie goes to the requester not granted last time.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) grant = ~last_grant_q;
        else if (req1_valid)          grant = 1'b1;
        req0_ready = (state_q == IDLE) && req0_valid && !grant;
        req1_ready = (state_q == IDLE) && req1_valid &&  grant;
        hs         = req0_ready || req1_ready;
    end

    // Next-state and datapath updates for the IDLE/EXEC/RESP sequence.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        cnt_d        = cnt_q;
        ctl_d        = ctl_q;
        ra_d         = ra_q;
        rb_d         = rb_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_branch_d = rsp_branch_q;
        case (state_q)
            IDLE: begin
                if (hs) begin
                    ctl_d        = grant ? req1_ctl : req0_ctl;
                    ra_d         = grant ? req1_ra  : req0_ra;
                    rb_d         = grant ? req1_rb  : req0_rb;
                    last_grant_d = grant;
                    id_d         = grant;
                    cnt_d        = CW'(EXEC_N - 1);
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    rsp_result_d = alu_result;
                    rsp_branch_d = alu_branch;
                    rsp_id_d     = id_q;
                    rsp_valid_d  = 1'b1;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                // No grant here: the next request waits for a full IDLE cycle.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            cnt_q        <= '0;
            ctl_q        <= '0;
            ra_q         <= '0;
            rb_q         <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_branch_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            cnt_q        <= cnt_d;
            ctl_q        <= ctl_d;
            ra_q         <= ra_d;
            rb_q         <= rb_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_branch_q <= rsp_branch_d;
        end
    end

    assign alu_ctl    = ctl_q;
    assign alu_ra     = ra_q;
    assign alu_rb     = rb_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_branch = rsp_branch_q;

`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] g0_q, g1_q, stall_q;

    // Free-running, wrapping counters of grants and response stall cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g0_q    <= '0;
            g1_q    <= '0;
            stall_q <= '0;
        end else begin
            if (req0_ready) g0_q <= g0_q + 1'b1;
            if (req1_ready) g1_q <= g1_q + 1'b1;
            if (state_q == RESP && !rsp_ready) stall_q <= stall_q + 1'b1;
        end
    end

    assign stat_grant0 = g0_q;
    assign stat_grant1 = g1_q;
    assign stat_stall  = stall_q;
`endif

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Bench for alu_issue_arbiter: a stub ALU, table vectors, tie/backpressure
// sequences, randomized traffic against a round-robin model, and a second
// instance with three settle cycles for latency and mid-EXEC reset.
module tb_alu_issue_arbiter;
    localparam int CNT_W = 2;
    localparam int E     = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, req0_valid, req0_ready, req1_valid, req1_ready;
    logic [55:0] req0_ctl, req1_ctl, alu_ctl;
    logic [63:0] req0_ra, req0_rb, req1_ra, req1_rb, alu_ra, alu_rb, alu_result, rsp_result;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_branch, alu_branch;

    logic        rst3_n, r3_v0, r3_rdy0, r3_v1, r3_rdy1;
    logic [55:0] r3_ctl0, r3_ctl1, r3_alu_ctl;
    logic [63:0] r3_ra0, r3_rb0, r3_ra1, r3_rb1, r3_alu_ra, r3_alu_rb, r3_alu_res, r3_rsp_res;
    logic        r3_rsp_valid, r3_rsp_ready, r3_rsp_id, r3_rsp_br, r3_alu_br;

`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] stat_grant0, stat_grant1, stat_stall, s3_g0, s3_g1, s3_st;
`endif

    // Stub ALU: a few recognisable operations, enough to prove pass-through.
    function automatic logic [64:0] alu_fn(input logic [55:0] c, input logic [63:0] a, input logic [63:0] b);
        logic [5:0]  op;
        logic [8:0]  xo;
        logic [15:0] si;
        op = c[55:50]; xo = c[49:41]; si = c[29:14];
        case (op)
            6'd31:   alu_fn = (xo == 9'd266) ? {1'b0, a + b} : (xo == 9'd40) ? {1'b0, b - a} : {1'b0, a ^ b};
            6'd36:   alu_fn = {1'b0, b + {{48{si[15]}}, si}};
            6'd19:   alu_fn = c[30] ? {a == b, a ^ b} : {$signed(a) < $signed(b), a ^ b};
            default: alu_fn = {1'b0, a ^ ~b};
        endcase
    endfunction

    function automatic logic [55:0] mk(input logic [5:0] op, input logic [8:0] xo, input logic aa, input logic [15:0] si);
        mk = {op, xo, 10'd0, aa, si, 14'd0};
    endfunction

    assign {alu_branch, alu_result} = alu_fn(alu_ctl, alu_ra, alu_rb);
    assign {r3_alu_br, r3_alu_res}  = alu_fn(r3_alu_ctl, r3_alu_ra, r3_alu_rb);

    alu_issue_arbiter #(.EXEC_CYCLES(E), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctl(req0_ctl), .req0_ra(req0_ra), .req0_rb(req0_rb),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctl(req1_ctl), .req1_ra(req1_ra), .req1_rb(req1_rb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_branch(rsp_branch),
        .alu_ctl(alu_ctl), .alu_ra(alu_ra), .alu_rb(alu_rb), .alu_result(alu_result), .alu_branch(alu_branch)
`ifdef ALU_ARB_STATS_EN
        , .stat_grant0(stat_grant0), .stat_grant1(stat_grant1), .stat_stall(stat_stall)
`endif
    );

    alu_issue_arbiter #(.EXEC_CYCLES(3), .CNT_W(CNT_W)) dut3 (
        .clk(clk), .rst_n(rst3_n),
        .req0_valid(r3_v0), .req0_ready(r3_rdy0), .req0_ctl(r3_ctl0), .req0_ra(r3_ra0), .req0_rb(r3_rb0),
        .req1_valid(r3_v1), .req1_ready(r3_rdy1), .req1_ctl(r3_ctl1), .req1_ra(r3_ra1), .req1_rb(r3_rb1),
        .rsp_valid(r3_rsp_valid), .rsp_ready(r3_rsp_ready), .rsp_id(r3_rsp_id), .rsp_result(r3_rsp_res), .rsp_branch(r3_rsp_br),
        .alu_ctl(r3_alu_ctl), .alu_ra(r3_alu_ra), .alu_rb(r3_alu_rb), .alu_result(r3_alu_res), .alu_branch(r3_alu_br)
`ifdef ALU_ARB_STATS_EN
        , .stat_grant0(s3_g0), .stat_grant1(s3_g1), .stat_stall(s3_st)
`endif
    );

    int n_pass = 0, n_tot = 0;
    // Reference model state: who was granted last, grant and stall tallies.
    bit mlast = 1'b1;
    int mg0 = 0, mg1 = 0, mstall = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    // Present requests from an IDLE DUT; the model decides the winner.
    task automatic send2(input bit v0, input bit v1,
                         input logic [55:0] c0, input logic [63:0] a0, input logic [63:0] b0,
                         input logic [55:0] c1, input logic [63:0] a1, input logic [63:0] b1,
                         output bit who);
        req0_valid = v0; req0_ctl = c0; req0_ra = a0; req0_rb = b0;
        req1_valid = v1; req1_ctl = c1; req1_ra = a1; req1_rb = b1;
        who = (v0 && v1) ? !mlast : v1;
        #1;
        chk("ready0", 64'(req0_ready), 64'(v0 && !who));
        chk("ready1", 64'(req1_ready), 64'(v1 && who));
        cyc();
        req0_valid = 1'b0; req1_valid = 1'b0;
        mlast = who;
        if (who) mg1++; else mg0++;
    endtask

    // Collect the response: latency, id, result, branch, then stall and consume.
    task automatic get(input bit who, input logic [63:0] er, input bit eb, input int stall, input string nm);
        int lat;
        logic [63:0] hold;
        rsp_ready = (stall == 0);
        lat = 0;
        while (!rsp_valid && lat < 30) begin cyc(); lat++; end
        chk({nm, "_lat"}, 64'(lat), 64'(E));
        chk({nm, "_id"}, 64'(rsp_id), 64'(who));
        chk({nm, "_res"}, rsp_result, er);
        chk({nm, "_br"}, 64'(rsp_branch), 64'(eb));
        hold = rsp_result;
        for (int i = 0; i < stall; i++) begin
            cyc();
            if (i == stall - 1) rsp_ready = 1'b1;
            #1;
            chk({nm, "_stall_v"}, 64'(rsp_valid), 64'd1);
            chk({nm, "_stall_res"}, rsp_result, hold);
            chk({nm, "_stall_rdy0"}, 64'(req0_ready), 64'd0);
        end
        mstall += stall;
        cyc();
        rsp_ready = 1'b1;
        chk({nm, "_drop"}, 64'(rsp_valid), 64'd0);
    endtask

    // Single request on the three-cycle instance, checked end to end.
    task automatic run3(input logic [55:0] c, input logic [63:0] a, input logic [63:0] b, input logic [63:0] er, input string nm);
        int lat;
        r3_v0 = 1'b1; r3_ctl0 = c; r3_ra0 = a; r3_rb0 = b;
        #1;
        chk({nm, "_rdy"}, 64'(r3_rdy0), 64'd1);
        cyc();
        r3_v0 = 1'b0;
        lat = 0;
        while (!r3_rsp_valid && lat < 30) begin cyc(); lat++; end
        chk({nm, "_lat"}, 64'(lat), 64'd3);
        chk({nm, "_res"}, r3_rsp_res, er);
        cyc();
    endtask

    typedef struct {
        bit          who;
        logic [55:0] ctl;
        logic [63:0] ra, rb, res;
        bit          br;
    } vec_t;
    vec_t tbl[6];

    initial begin
        bit          who;
        logic [55:0] c0, c1, cw;
        logic [63:0] a0, b0, a1, b1, aw, bw;
        logic [64:0] ex;
        logic [5:0]  ops[4];
        bit          seen;

        tbl[0] = '{1'b0, mk(6'd31, 9'd266, 1'b0, 16'd0),    64'd3,  64'd5,   64'd8,    1'b0};
        tbl[1] = '{1'b1, mk(6'd19, 9'd0,   1'b0, 16'd0),    64'd3,  64'd4,   64'd7,    1'b1};
        tbl[2] = '{1'b1, mk(6'd19, 9'd0,   1'b1, 16'd0),    64'd9,  64'd9,   64'd0,    1'b1};
        tbl[3] = '{1'b0, mk(6'd31, 9'd40,  1'b0, 16'd0),    64'd14, 64'd31,  64'd17,   1'b0};
        tbl[4] = '{1'b1, mk(6'd36, 9'd0,   1'b0, 16'd1000), 64'd0,  64'd8,   64'd1008, 1'b0};
        tbl[5] = '{1'b0, mk(6'd36, 9'd0,   1'b0, 16'hFFFC), 64'd0,  64'd100, 64'd96,   1'b0};
        ops[0] = 6'd31; ops[1] = 6'd36; ops[2] = 6'd19; ops[3] = 6'd7;

        rst_n = 1'b0; rst3_n = 1'b0; rsp_ready = 1'b1; r3_rsp_ready = 1'b1;
        req0_valid = 0; req1_valid = 0; req0_ctl = '0; req1_ctl = '0;
        req0_ra = '0; req0_rb = '0; req1_ra = '0; req1_rb = '0;
        r3_v0 = 0; r3_v1 = 0; r3_ctl0 = '0; r3_ctl1 = '0;
        r3_ra0 = '0; r3_rb0 = '0; r3_ra1 = '0; r3_rb1 = '0;
        repeat (3) cyc();
        rst_n = 1'b1; rst3_n = 1'b1;
        cyc();

        // Reset state.
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_res", rsp_result, 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("rst_alu_ctl", 64'(alu_ctl), 64'd0);
        chk("rst_alu_ra", alu_ra, 64'd0);
        chk("rst_ready0", 64'(req0_ready), 64'd0);

        // Tie right after reset: requester 0 first, then 1, then a tie goes to 0.
        send2(1, 1, tbl[3].ctl, tbl[3].ra, tbl[3].rb, tbl[4].ctl, tbl[4].ra, tbl[4].rb, who);
        get(who, 64'd17, 1'b0, 0, "tie_a");
        send2(0, 1, '0, '0, '0, tbl[4].ctl, tbl[4].ra, tbl[4].rb, who);
        get(who, 64'd1008, 1'b0, 0, "tie_b");
        send2(1, 1, tbl[0].ctl, tbl[0].ra, tbl[0].rb, tbl[4].ctl, tbl[4].ra, tbl[4].rb, who);
        get(who, 64'd8, 1'b0, 0, "tie_c");

        // Table vectors, one requester at a time.
        for (int i = 0; i < 6; i++) begin
            vec_t v;
            v = tbl[i];
            send2(!v.who, v.who, v.ctl, v.ra, v.rb, v.ctl, v.ra, v.rb, who);
            get(v.who, v.res, v.br, 0, $sformatf("vec%0d", i));
        end
        chk("alu_hold_ra", alu_ra, 64'd0);
        chk("alu_hold_rb", alu_rb, 64'd100);

        // Backpressure with requester 0 kept valid throughout.
        send2(1, 0, tbl[0].ctl, 64'd40, 64'd2, '0, '0, '0, who);
        req0_valid = 1'b1; req0_ctl = tbl[3].ctl; req0_ra = 64'd1; req0_rb = 64'd11;
        get(who, 64'd42, 1'b0, 5, "bp");
        chk("bp_idle_grant", 64'(req0_ready), 64'd1);
        cyc();
        req0_valid = 1'b0; mlast = 1'b0; mg0++;
        get(1'b0, 64'd10, 1'b0, 0, "bp_next");
`ifdef ALU_ARB_STATS_EN
        chk("stat_stall", 64'(stat_stall), 64'(mstall % (1 << CNT_W)));
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 40; i++) begin
            int vm, st;
            vm = int'($urandom_range(1, 3));
            c0 = {ops[$urandom_range(0, 3)], 50'($urandom) ^ {$urandom, 18'd0}};
            c1 = {ops[$urandom_range(0, 3)], 50'($urandom) ^ {$urandom, 18'd0}};
            a0 = {$urandom, $urandom}; b0 = {$urandom, $urandom};
            a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
            st = int'($urandom_range(0, 2));
            send2(vm[0], vm[1], c0, a0, b0, c1, a1, b1, who);
            cw = who ? c1 : c0; aw = who ? a1 : a0; bw = who ? b1 : b0;
            ex = alu_fn(cw, aw, bw);
            get(who, ex[63:0], ex[64], st, $sformatf("rnd%0d", i));
        end
`ifdef ALU_ARB_STATS_EN
        chk("stat_grant0", 64'(stat_grant0), 64'(mg0 % (1 << CNT_W)));
        chk("stat_grant1", 64'(stat_grant1), 64'(mg1 % (1 << CNT_W)));
        chk("stat_stall_end", 64'(stat_stall), 64'(mstall % (1 << CNT_W)));
`endif

        // Three settle cycles: latency, then reset in the second EXEC cycle.
        run3(tbl[0].ctl, 64'd3, 64'd5, 64'd8, "e3_a");
        r3_v0 = 1'b1; r3_ctl0 = tbl[3].ctl; r3_ra0 = 64'd2; r3_rb0 = 64'd9;
        cyc();
        r3_v0 = 1'b0;
        cyc();
        chk("e3_alu_held", 64'(r3_alu_ctl), 64'(tbl[3].ctl));
        #2 rst3_n = 1'b0;
        #1;
        chk("e3_rst_ctl", 64'(r3_alu_ctl), 64'd0);
        chk("e3_rst_ra", r3_alu_ra, 64'd0);
        chk("e3_rst_res", r3_rsp_res, 64'd0);
        chk("e3_rst_valid", 64'(r3_rsp_valid), 64'd0);
        cyc();
        rst3_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (r3_rsp_valid) seen = 1'b1;
            cyc();
        end
        chk("e3_no_rsp", 64'(seen), 64'd0);
        run3(tbl[4].ctl, 64'd0, 64'd8, 64'd1008, "e3_b");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    // Hard stop if something above stops making progress.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
